// File: rtl/hazard_pkg.sv
// Shared types and decode helpers for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        HZ_IDLE     = 1'b0,
        HZ_MDU_WAIT = 1'b1
    } hz_state_e;

    // Register addresses are zero-extended to this width before comparison.
    localparam int MAX_AW = 32;
    localparam logic [MAX_AW-1:0] REG_ZERO = '0;

    function automatic logic is_taken(input logic jump,
                                      input logic beq,
                                      input logic bne,
                                      input logic eq,
                                      input logic ne);
        return jump | (beq & eq) | (bne & ne);
    endfunction

    function automatic logic is_load_use(input logic              ex_mem_read,
                                         input logic [MAX_AW-1:0] ex_rt,
                                         input logic [MAX_AW-1:0] id_rs,
                                         input logic [MAX_AW-1:0] id_rt,
                                         input logic              uses_rs,
                                         input logic              uses_rt);
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((uses_rs && (id_rs == ex_rt)) || (uses_rt && (id_rt == ex_rt)));
    endfunction

endpackage

// File: rtl/hazard_down_counter.sv
// Loadable down counter that stops at zero; load wins over decrement.
module hazard_down_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         is_zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller beside ID: control-transfer flush window, load-use stall,
// multi-cycle MDU freeze, and a saturating count of PC-stalled cycles.
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MDU_LATENCY  = 4,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              jump,
    input  logic              branch_equal,
    input  logic              branch_not_equal,
    input  logic              equal,
    input  logic              not_equal,
    input  logic              mdu_start,
    output logic              pc_ld,
    output logic              IF_ID_write,
    output logic              id_ex_bubble,
    output logic              ex_freeze,
    output logic              flush,
    output logic              mdu_busy,
    output logic [STAT_W-1:0] stall_count
);

    import hazard_pkg::*;

    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
    localparam int MDU_W   = $clog2(MDU_LATENCY + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [MDU_W-1:0]   MDU_LOAD   = MDU_W'((MDU_LATENCY > 1) ? MDU_LATENCY - 2 : 0);

    hz_state_e         state_q, state_d;
    logic [STAT_W-1:0] stall_q, stall_d;
    logic              flush_load, flush_dec, flush_zero;
    logic              mdu_load, mdu_dec, mdu_zero;
    logic              taken, load_use;
    logic              pc_ld_raw, if_id_raw, bubble_raw, freeze_raw, flush_raw;

    assign taken    = is_taken(jump, branch_equal, branch_not_equal, equal, not_equal);
    assign load_use = is_load_use(ex_mem_read, MAX_AW'(ex_rt), MAX_AW'(id_rs), MAX_AW'(id_rt),
                                  id_uses_rs, id_uses_rt);

    hazard_down_counter #(.W(FLUSH_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (flush_load),
        .value   (FLUSH_LOAD),
        .dec     (flush_dec),
        .is_zero (flush_zero)
    );

    hazard_down_counter #(.W(MDU_W)) u_mdu_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mdu_load),
        .value   (MDU_LOAD),
        .dec     (mdu_dec),
        .is_zero (mdu_zero)
    );

    always_comb begin
        state_d    = state_q;
        pc_ld_raw  = 1'b1;
        if_id_raw  = 1'b1;
        bubble_raw = 1'b0;
        freeze_raw = 1'b0;
        flush_raw  = 1'b0;
        flush_load = 1'b0;
        mdu_load   = 1'b0;
        mdu_dec    = 1'b0;
        // The flush window keeps draining even while the MDU holds the pipe.
        flush_dec  = !flush_zero;

        if (state_q == HZ_MDU_WAIT) begin
            pc_ld_raw  = 1'b0;
            if_id_raw  = 1'b0;
            freeze_raw = 1'b1;
            if (mdu_zero) begin
                state_d = HZ_IDLE;
            end else begin
                mdu_dec = 1'b1;
            end
        end else if (!flush_zero) begin
            flush_raw = 1'b1;
        end else begin
            if (taken) begin
                flush_raw  = 1'b1;
                flush_load = 1'b1;
            end else if (load_use) begin
                pc_ld_raw  = 1'b0;
                if_id_raw  = 1'b0;
                bubble_raw = 1'b1;
            end
            if (mdu_start && (MDU_LATENCY > 1)) begin
                state_d  = HZ_MDU_WAIT;
                mdu_load = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_ld_raw && (stall_q != {STAT_W{1'b1}})) begin
            stall_d = stall_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_IDLE;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    // Reset forces a safe squash/hold pattern regardless of state.
    always_comb begin
        pc_ld        = pc_ld_raw;
        IF_ID_write  = if_id_raw;
        id_ex_bubble = bubble_raw;
        ex_freeze    = freeze_raw;
        flush        = flush_raw;
        mdu_busy     = (state_q == HZ_MDU_WAIT);
        if (!rst_n) begin
            pc_ld        = 1'b0;
            IF_ID_write  = 1'b0;
            id_ex_bubble = 1'b1;
            ex_freeze    = 1'b0;
            flush        = 1'b1;
            mdu_busy     = 1'b0;
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: three controller instances (default, 3-cycle flush window,
// single-cycle MDU with 2-bit stall counter) share one stimulus stream.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
    logic       jump = 1'b0, branch_equal = 1'b0, branch_not_equal = 1'b0;
    logic       equal = 1'b0, not_equal = 1'b0, mdu_start = 1'b0;

    // {pc_ld, IF_ID_write, id_ex_bubble, ex_freeze, flush}
    logic [4:0]  o0, o1, o2;
    logic        busy0, busy1, busy2;
    logic [15:0] sc0, sc1;
    logic [1:0]  sc2;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [4:0] RST  = 5'b00101;
    localparam logic [4:0] NORM = 5'b11000;
    localparam logic [4:0] STL  = 5'b00100;
    localparam logic [4:0] FRZ  = 5'b00010;
    localparam logic [4:0] FLS  = 5'b11001;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .jump(jump),
        .branch_equal(branch_equal), .branch_not_equal(branch_not_equal),
        .equal(equal), .not_equal(not_equal), .mdu_start(mdu_start),
        .pc_ld(o0[4]), .IF_ID_write(o0[3]), .id_ex_bubble(o0[2]),
        .ex_freeze(o0[1]), .flush(o0[0]), .mdu_busy(busy0), .stall_count(sc0)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .jump(jump),
        .branch_equal(branch_equal), .branch_not_equal(branch_not_equal),
        .equal(equal), .not_equal(not_equal), .mdu_start(mdu_start),
        .pc_ld(o1[4]), .IF_ID_write(o1[3]), .id_ex_bubble(o1[2]),
        .ex_freeze(o1[1]), .flush(o1[0]), .mdu_busy(busy1), .stall_count(sc1)
    );

    pipeline_hazard_ctrl #(.MDU_LATENCY(1), .STAT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .jump(jump),
        .branch_equal(branch_equal), .branch_not_equal(branch_not_equal),
        .equal(equal), .not_equal(not_equal), .mdu_start(mdu_start),
        .pc_ld(o2[4]), .IF_ID_write(o2[3]), .id_ex_bubble(o2[2]),
        .ex_freeze(o2[1]), .flush(o2[0]), .mdu_busy(busy2), .stall_count(sc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        jump = 1'b0; branch_equal = 1'b0; branch_not_equal = 1'b0;
        equal = 1'b0; not_equal = 1'b0; mdu_start = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    endtask

    initial begin
        // Reset values while rst_n is low
        clear_inputs();
        #3;
        chk("rst_outs", 32'(o0), 32'(RST));
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_count", 32'(sc0), 32'd0);
        #4;
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", 32'(o0), 32'(NORM));

        // Load-use: one-cycle stall, then r0 destination never stalls
        do_reset();
        set_load_use();
        #1;
        chk("lu_stall", 32'(o0), 32'(STL));
        tick();
        ex_mem_read = 1'b0;
        #1;
        chk("lu_release", 32'(o0), 32'(NORM));
        chk("lu_count", 32'(sc0), 32'd1);
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("lu_r0_nostall", 32'(o0), 32'(NORM));
        id_uses_rs = 1'b0; id_uses_rt = 1'b1; id_rt = 5'd9; ex_rt = 5'd9;
        #1;
        chk("lu_rt_stall", 32'(o0), 32'(STL));

        // Flush window of 3 with a jump in cycle 2 and a load-use in cycle 3
        do_reset();
        branch_equal = 1'b1; equal = 1'b1;
        #1;
        chk("fl3_c1", 32'(o1), 32'(FLS));
        chk("fl1_c1", 32'(o0), 32'(FLS));
        tick();
        branch_equal = 1'b0; equal = 1'b0; jump = 1'b1;
        #1;
        chk("fl3_c2", 32'(o1), 32'(FLS));
        tick();
        jump = 1'b0;
        set_load_use();
        #1;
        chk("fl3_c3_lu_ignored", 32'(o1), 32'(FLS));
        chk("fl1_lu_stalls", 32'(o0), 32'(STL));
        tick();
        clear_inputs();
        #1;
        chk("fl3_end_noext", 32'(o1), 32'(NORM));
        chk("fl3_count", 32'(sc1), 32'd0);
        branch_not_equal = 1'b1; not_equal = 1'b1;
        #1;
        chk("bne_taken", 32'(o1), 32'(FLS));
        not_equal = 1'b0;
        #1;
        chk("bne_not_taken", 32'(o1), 32'(NORM));

        // MDU freeze for MDU_LATENCY-1 cycles; latency 1 never freezes
        do_reset();
        mdu_start = 1'b1;
        #1;
        chk("mdu_start_cycle", 32'(o0), 32'(NORM));
        tick();
        mdu_start = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mdu_freeze_%0d", i), 32'(o0), 32'(FRZ));
            chk($sformatf("mdu_busy_%0d", i), 32'(busy0), 32'd1);
            tick();
        end
        chk("mdu_done", 32'(o0), 32'(NORM));
        chk("mdu_done_busy", 32'(busy0), 32'd0);
        chk("mdu_count", 32'(sc0), 32'd3);
        chk("mdu_lat1_nofreeze", 32'(o2), 32'(NORM));
        chk("mdu_lat1_count", 32'(sc2), 32'd0);

        // Branch held in ID during the freeze flushes only after it
        do_reset();
        mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        branch_equal = 1'b1; equal = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("br_in_freeze_%0d", i), 32'(o0), 32'(FRZ));
            tick();
        end
        chk("br_after_freeze", 32'(o0), 32'(FLS));
        tick();
        clear_inputs();
        #1;
        chk("br_after_flush", 32'(o0), 32'(NORM));

        // mdu_start with a jump: flush now, freeze next
        do_reset();
        mdu_start = 1'b1; jump = 1'b1;
        #1;
        chk("mdu_jump_same", 32'(o0), 32'(FLS));
        tick();
        clear_inputs();
        #1;
        chk("mdu_jump_next", 32'(o0), 32'(FRZ));

        // taken beats load_use in the same cycle
        do_reset();
        set_load_use();
        jump = 1'b1;
        #1;
        chk("taken_over_lu", 32'(o0), 32'(FLS));

        // Reset asserted mid-freeze aborts immediately
        do_reset();
        mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        tick();
        chk("pre_abort_freeze", 32'(o0), 32'(FRZ));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outs", 32'(o0), 32'(RST));
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_count", 32'(sc0), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort_release", 32'(o0), 32'(NORM));
        tick();
        chk("abort_release_next", 32'(o0), 32'(NORM));
        chk("abort_release_count", 32'(sc0), 32'd0);

        // 2-bit stall counter saturates at 3
        do_reset();
        set_load_use();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("sat_count_%0d", i), 32'(sc2), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        chk("sat_wide_count", 32'(sc0), 32'd5);
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
